seven_seg_bank: RTL and testbench

SEVEN_SEG_BANK -- requirements
Module: seven_seg_bank

---
 rtl/seven_seg_bank.sv | 189 ++++++++++++++++++
 tb/tb_seven_seg_bank.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_bank.sv
// Seven-segment display bank: hex or sequential binary-to-BCD decimal, leading-zero
// blanking and decimal overflow dashes. Optional per-digit blink when SEG_BLINK_EN is defined.
module seven_seg_bank #(
  parameter int NUM_DIGITS = 6,
  parameter int DATA_W     = 20,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [DATA_W-1:0]       i_value,
  input  logic                    i_mode,
  input  logic                    i_blank_lz,
  input  logic [NUM_DIGITS-1:0]   i_blink_mask,
  output logic [7*NUM_DIGITS-1:0] o_seg,
  output logic                    o_done,
  output logic                    o_ovf
);

  localparam int NIB_W = 4 * NUM_DIGITS;
  localparam int SEG_W = 7 * NUM_DIGITS;

  typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  value_q, value_d;
  logic [NIB_W-1:0]   bcd_q, bcd_d;
  logic               carry_q, carry_d;
  logic               mode_q, mode_d;
  logic               blank_q, blank_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [SEG_W-1:0]   seg_q, seg_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;

  logic [NIB_W-1:0]   bcd_adj;
  logic [NIB_W-1:0]   nib;
  logic [31:0]        value_ext;
  logic [3:0]         dig;
  logic               seen;

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    case (d)
      4'h0: seg_enc = 7'b1000000;
      4'h1: seg_enc = 7'b1111001;
      4'h2: seg_enc = 7'b0100100;
      4'h3: seg_enc = 7'b0110000;
      4'h4: seg_enc = 7'b0011001;
      4'h5: seg_enc = 7'b0010010;
      4'h6: seg_enc = 7'b0000010;
      4'h7: seg_enc = 7'b1011000;
      4'h8: seg_enc = 7'b0000000;
      4'h9: seg_enc = 7'b0011000;
      4'hA: seg_enc = 7'b0001000;
      4'hB: seg_enc = 7'b0000011;
      4'hC: seg_enc = 7'b1000110;
      4'hD: seg_enc = 7'b0100001;
      4'hE: seg_enc = 7'b0000110;
      default: seg_enc = 7'b0001110;
    endcase
  endfunction

  assign value_ext = 32'(value_q);
  assign o_ready   = (state_q == IDLE);
  assign o_done    = done_q;
  assign o_ovf     = ovf_q;

  always_comb begin
    state_d = state_q;
    value_d = value_q;
    bcd_d   = bcd_q;
    carry_d = carry_q;
    mode_d  = mode_q;
    blank_d = blank_q;
    cnt_d   = cnt_q;
    seg_d   = seg_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    dig     = '0;
    seen    = 1'b0;

    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      bcd_adj[4*k +: 4] = (bcd_q[4*k +: 4] >= 4'd5) ? bcd_q[4*k +: 4] + 4'd3 : bcd_q[4*k +: 4];
    end
    nib = mode_q ? bcd_q : value_ext[NIB_W-1:0];

    case (state_q)
      IDLE: begin
        if (i_valid) begin
          value_d = i_value;
          bcd_d   = '0;
          carry_d = 1'b0;
          mode_d  = i_mode;
          blank_d = i_blank_lz;
          cnt_d   = '0;
          state_d = i_mode ? CONVERT : UPDATE;
        end
      end
      CONVERT: begin
        // A digit carried out of the top BCD position means the value has no
        // room in NUM_DIGITS decimal digits; keep it sticky for the overflow flag.
        carry_d = carry_q | bcd_adj[NIB_W-1];
        bcd_d   = {bcd_adj[NIB_W-2:0], value_q[DATA_W-1]};
        value_d = value_q << 1;
        cnt_d   = cnt_q + 6'd1;
        if (cnt_q == 6'(DATA_W - 1)) state_d = UPDATE;
      end
      UPDATE: begin
        done_d  = 1'b1;
        ovf_d   = mode_q & carry_q;
        state_d = IDLE;
        // Scan from the top digit down so leading zeros can be blanked.
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
          dig = nib[4*(NUM_DIGITS-1-k) +: 4];
          if (mode_q && carry_q)
            seg_d[7*(NUM_DIGITS-1-k) +: 7] = 7'b0111111;
          else if (blank_q && !seen && dig == 4'd0 && (k + 1) != NUM_DIGITS)
            seg_d[7*(NUM_DIGITS-1-k) +: 7] = 7'b1111111;
          else
            seg_d[7*(NUM_DIGITS-1-k) +: 7] = seg_enc(dig);
          seen = seen | (dig != 4'd0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
      value_q <= '0;
      bcd_q   <= '0;
      carry_q <= 1'b0;
      mode_q  <= 1'b0;
      blank_q <= 1'b0;
      cnt_q   <= '0;
      seg_q   <= '1;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      bcd_q   <= bcd_d;
      carry_q <= carry_d;
      mode_q  <= mode_d;
      blank_q <= blank_d;
      cnt_q   <= cnt_d;
      seg_q   <= seg_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef SEG_BLINK_EN
  logic [31:0]      blink_cnt_q, blink_cnt_d;
  logic             phase_q, phase_d;
  logic [SEG_W-1:0] blink_seg;

  always_comb begin
    blink_cnt_d = blink_cnt_q + 32'd1;
    phase_d     = phase_q;
    if (blink_cnt_q == 32'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
    for (int unsigned n = 0; n < NUM_DIGITS; n++) begin
      blink_seg[7*n +: 7] = {7{phase_q & i_blink_mask[n]}};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign o_seg = seg_q | blink_seg;
`else
  logic unused_blink;
  assign unused_blink = ^{i_blink_mask, 32'(BLINK_DIV)};
  assign o_seg = seg_q;
`endif

endmodule

// File: tb/tb_seven_seg_bank.sv
// Directed self-checking bench for seven_seg_bank (NUM_DIGITS=6, DATA_W=20).
module tb_seven_seg_bank;
  localparam int ND = 6;
  localparam int DW = 20;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S6 = 7'b0000010, S9 = 7'b0011000, SA = 7'b0001000,
                         SBb = 7'b0000011, SC = 7'b1000110, SDd = 7'b0100001,
                         SF = 7'b0001110, BL = 7'b1111111, DA = 7'b0111111;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            i_valid = 1'b0;
  logic            i_mode = 1'b0;
  logic            i_blank_lz = 1'b0;
  logic [DW-1:0]   i_value = '0;
  logic [ND-1:0]   i_blink_mask = '0;
  logic            o_ready, o_done, o_ovf;
  logic [7*ND-1:0] o_seg;

  int n_checks = 0;
  int n_fail   = 0;
  int lat;
  int extra_done;
  logic [7*ND-1:0] seg_hold;
  logic [6:0] d0, p0;
  int run_len, n_tog;

  always #5 clk = ~clk;

  seven_seg_bank #(
    .NUM_DIGITS (ND),
    .DATA_W     (DW),
    .BLINK_DIV  (4)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_value      (i_value),
    .i_mode       (i_mode),
    .i_blank_lz   (i_blank_lz),
    .i_blink_mask (i_blink_mask),
    .o_seg        (o_seg),
    .o_done       (o_done),
    .o_ovf        (o_ovf)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request and return the cycle count from the accept edge to o_done (-1 on timeout).
  task automatic run_req(input logic [DW-1:0] v, input logic m, input logic b,
                         input bit poke, output int latency);
    @(negedge clk);
    i_valid = 1'b1; i_value = v; i_mode = m; i_blank_lz = b;
    @(posedge clk);
    latency = -1;
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      i_valid = poke && (k == 4);
      if (poke && k == 4) begin
        i_value = 20'h00007; i_mode = 1'b0;
      end
      if (o_done) begin
        latency = k;
        break;
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_seg",   64'(o_seg),   64'({42{1'b1}}));
    chk("rst_done",  64'(o_done),  64'd0);
    chk("rst_ovf",   64'(o_ovf),   64'd0);
    chk("rst_ready", 64'(o_ready), 64'd1);
    rst = 1'b1;
    @(negedge clk);

    run_req(20'h0ABCD, 1'b0, 1'b0, 1'b0, lat);
    chk("hex_lat", 64'(lat),   64'd1);
    chk("hex_seg", 64'(o_seg), 64'({S0, S0, SA, SBb, SC, SDd}));
    chk("hex_ovf", 64'(o_ovf), 64'd0);
    @(negedge clk);
    chk("hex_done_pulse", 64'(o_done),  64'd0);
    chk("hex_ready",      64'(o_ready), 64'd1);

    run_req(20'hFFFFF, 1'b0, 1'b0, 1'b0, lat);
    chk("hex_top_nib", 64'(o_seg), 64'({S0, SF, SF, SF, SF, SF}));

    run_req(20'h0000F, 1'b0, 1'b1, 1'b0, lat);
    chk("hex_blank_lz", 64'(o_seg), 64'({BL, BL, BL, BL, BL, SF}));

    run_req(20'd123456, 1'b1, 1'b0, 1'b1, lat);
    chk("dec_lat", 64'(lat),   64'd21);
    chk("dec_seg", 64'(o_seg), 64'({S1, S2, S3, S4, S5, S6}));
    chk("dec_ovf", 64'(o_ovf), 64'd0);
    seg_hold = o_seg;
    extra_done = 0;
    repeat (6) begin
      @(negedge clk);
      if (o_done) extra_done++;
    end
    chk("poke_no_done", 64'(extra_done), 64'd0);
    chk("poke_seg_kept", 64'(o_seg), 64'(seg_hold));

    run_req(20'd42, 1'b1, 1'b1, 1'b0, lat);
    chk("dec42_lat", 64'(lat),   64'd21);
    chk("dec42_seg", 64'(o_seg), 64'({BL, BL, BL, BL, S4, S2}));

    run_req(20'd0, 1'b1, 1'b1, 1'b0, lat);
    chk("dec0_seg", 64'(o_seg), 64'({BL, BL, BL, BL, BL, S0}));

    run_req(20'd1000000, 1'b1, 1'b0, 1'b0, lat);
    chk("ovf_flag", 64'(o_ovf), 64'd1);
    chk("ovf_seg",  64'(o_seg), 64'({DA, DA, DA, DA, DA, DA}));

    // Reset ten cycles into a decimal conversion.
    @(negedge clk);
    i_valid = 1'b1; i_value = 20'd555555; i_mode = 1'b1; i_blank_lz = 1'b0;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("mid_busy", 64'(o_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("mid_rst_seg",  64'(o_seg),  64'({42{1'b1}}));
    chk("mid_rst_done", 64'(o_done), 64'd0);
    chk("mid_rst_ovf",  64'(o_ovf),  64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rel_ready", 64'(o_ready), 64'd1);
    extra_done = 0;
    repeat (25) begin
      @(negedge clk);
      if (o_done) extra_done++;
    end
    chk("rel_no_done", 64'(extra_done), 64'd0);

    run_req(20'd999999, 1'b1, 1'b0, 1'b0, lat);
    chk("dec9_lat", 64'(lat),   64'd21);
    chk("dec9_ovf", 64'(o_ovf), 64'd0);
    chk("dec9_seg", 64'(o_seg), 64'({S9, S9, S9, S9, S9, S9}));

    i_blink_mask = 6'b000001;
`ifdef SEG_BLINK_EN
    @(negedge clk);
    p0 = o_seg[6:0];
    run_len = 1;
    n_tog = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      d0 = o_seg[6:0];
      chk("blink_hi_steady", 64'(o_seg[41:7]), 64'({S9, S9, S9, S9, S9}));
      chk("blink_d0_code", 64'(d0 == S9 || d0 == BL), 64'd1);
      if (d0 != p0) begin
        if (n_tog > 0) chk("blink_run", 64'(run_len), 64'd4);
        n_tog++;
        run_len = 1;
      end else begin
        run_len++;
      end
      p0 = d0;
    end
    chk("blink_toggles", 64'(n_tog >= 5), 64'd1);
`else
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("no_blink_steady", 64'(o_seg), 64'({S9, S9, S9, S9, S9, S9}));
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
